reg_bank_wr_arbiter: RTL
========================

# reg_bank_wr_arbiter

Write-port arbiter and sequencer for the 32×32 register bank. Two writeback sources (requester 0: ALU writeback; requester 1: memory/load writeback) share the bank's single write port (Awrite, DataIn, WReg) through a valid/ready handshake with round-robin priority. The block also:
- registers the winning write for one cycle,
- discards writes to register 0 when configured to,
- flags read-after-write hazards on the two bank read addresses,
- keeps a saturating committed-write counter.

## Interface
Parameters:
- AW, 5, register address width (bank depth 2^AW)
- DW, 32, data width
- ZERO_DISCARD, 1, 1 = writes to address 0 are accepted but never drive WReg
- CW, 16, width of committed-write counter

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  1 = grant nothing this cycle (pipeline stall)
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  DW  requester 0 write data
- req0_ready  out  1  requester 0 granted this cycle (combinational)
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0
- WReg  out  1  bank write enable (registered)
- Awrite  out  AW  bank write address (registered)
- DataIn  out  DW  bank write data (registered)
- rd_addr1  in  AW  bank AR1 as currently driven by the decoder
- rd_addr2  in  AW  bank AR2 as currently driven by the decoder
- hazard1  out  1  rd_addr1 matches the write in flight (combinational)
- hazard2  out  1  rd_addr2 matches the write in flight (combinational)
- wr_count  out  CW  number of committed bank writes, saturating

## Operation
- Grant logic, combinational, evaluated each cycle:
  - If hold = 1: no grant.
  - Else, only one valid: grant it.
  - Else, both valid: grant the requester not granted most recently (last_gnt).
  - Neither valid: no grant.
- reqX_ready is the grant itself. A transfer happens on a clock edge where reqX_valid & reqX_ready. At most one ready is high per cycle.
- last_gnt updates only on a transfer. Reset value is 1, so requester 0 wins the first contention.
- Output stage, on each edge:
  - Awrite/DataIn load the transferred addr/data.
  - WReg = transfer & !(ZERO_DISCARD & addr == 0).
  - With no transfer: WReg = 0 and Awrite/DataIn hold their previous values.
- The bank always accepts a write, so the output stage never stalls. Throughput is one write per cycle.
- Hazards:
  - hazard1 = WReg & (rd_addr1 == Awrite).
  - hazard2 = WReg & (rd_addr2 == Awrite).
  - A discarded address-0 write raises no hazard.
- wr_count increments on every cycle with WReg = 1 and saturates at 2^CW−1, with no wrap.
- A requester must hold valid/addr/data stable until ready. The block does not check this.

## Timing
- Reset (rst_n low, asynchronous, immediate) drives: WReg = 0, Awrite = 0, DataIn = 0, wr_count = 0, last_gnt = 1.
  - Therefore hazard1 = hazard2 = 0. readys follow the grant logic combinationally.
- Reset mid-operation: a write in the output stage is dropped, with no bank write. Requests not yet transferred remain the requesters' responsibility.
- Latency: transfer at edge N → WReg/Awrite/DataIn valid during cycle N+1 → bank captures at edge N+1 → data readable on DR1/DR2 from cycle N+2.
- hazard1/hazard2 are meaningful during cycle N+1 only, the window in which the bank does not yet hold the new value.
- hold asserted in cycle N: no transfer at edge N, and WReg = 0 in cycle N+1. last_gnt is unchanged.
- Back-to-back writes to the same address: both commit, in grant order. The second value is final.
- Simultaneous requests to the same address: the round-robin winner commits first and the loser commits the following cycle. The loser's data is final.

## Test plan
- Reset: hold rst_n = 0 while req0_valid = 1 → WReg = 0, wr_count = 0, hazards 0. Release reset → first edge transfers req0.
- Single requester: req0 (addr 9, data 358) for one cycle → req0_ready = 1. Next cycle WReg = 1, Awrite = 9, DataIn = 358. wr_count = 1.
- Contention: req0 (15, 0xAAAA) and req1 (15, 0x5555) both valid for 3 cycles → grants 0, 1, 0. Bank reg 15 ends at 0xAAAA from req0's second transfer. wr_count = 3.
- Zero discard: req1 (addr 0, data 0xFFFF_FFFF) → req1_ready = 1, WReg stays 0, wr_count unchanged, hazards 0.
- Hazard: req0 (4, 77) transferred. Next cycle rd_addr1 = 4, rd_addr2 = 2 → hazard1 = 1, hazard2 = 0. Following cycle hazard1 = 0, and DR1 reads 77.
- Hold and saturation:
  - hold = 1 with both valid → both readys 0 and WReg 0 the next cycle.
  - With CW = 2: 5 consecutive writes → wr_count stops at 3.

Source files
------------

// File: rtl/reg_bank_wr_arbiter.sv
// Write-port arbiter for the 32x32 register bank: round-robin between ALU and
// load writeback, one registered write per cycle, RAW hazard flags, write counter.
module reg_bank_wr_arbiter #(
  parameter int unsigned AW           = 5,
  parameter int unsigned DW           = 32,
  parameter bit          ZERO_DISCARD = 1'b1,
  parameter int unsigned CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          WReg,
  output logic [AW-1:0] Awrite,
  output logic [DW-1:0] DataIn,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          hazard1,
  output logic          hazard2,
  output logic [CW-1:0] wr_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  logic          last_gnt_q, last_gnt_d;
  logic          wreg_q, wreg_d;
  wr_req_t       wr_q, wr_d;
  logic [CW-1:0] wr_count_q, wr_count_d;

  logic          gnt0_c, gnt1_c;
  logic          xfer_c;
  logic          discard_c;
  wr_req_t       win_c;

  // Round-robin grant; on contention the requester not served last wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        gnt0_c = last_gnt_q;
        gnt1_c = !last_gnt_q;
      end else begin
        gnt0_c = req0_valid;
        gnt1_c = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // Winning payload and whether it is a discarded register-0 write.
  always_comb begin
    win_c     = gnt1_c ? wr_req_t'({req1_addr, req1_data})
                       : wr_req_t'({req0_addr, req0_data});
    xfer_c    = gnt0_c || gnt1_c;
    discard_c = ZERO_DISCARD && (win_c.addr == '0);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    wreg_d     = 1'b0;
    wr_d       = wr_q;
    wr_count_d = wr_count_q;
    if (xfer_c) begin
      last_gnt_d = gnt1_c;
      wreg_d     = !discard_c;
      wr_d       = win_c;
    end
    // Count writes the bank commits, saturating instead of wrapping.
    if (wreg_q && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      wreg_q     <= 1'b0;
      wr_q       <= '0;
      wr_count_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      wreg_q     <= wreg_d;
      wr_q       <= wr_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign WReg     = wreg_q;
  assign Awrite   = wr_q.addr;
  assign DataIn   = wr_q.data;
  assign wr_count = wr_count_q;

  // Reads that hit the write still in flight see stale bank contents.
  assign hazard1 = wreg_q && (rd_addr1 == wr_q.addr);
  assign hazard2 = wreg_q && (rd_addr2 == wr_q.addr);

endmodule
